// File: rtl/reg_bank16.sv
// 16-entry register bank fed by a one-hot write-select bus, with two registered read ports.
// Optional macro REGBANK_BYPASS_EN: write-first forwarding on read/write collisions (default read-first).
module reg_bank16 #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned ZERO_REG0 = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      wr_en_1hot,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [3:0]       rd_addr_a,
    input  logic [3:0]       rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic             clr_error,
    output logic             wr_error
);

    localparam int unsigned NREG = 16;
    localparam bit          ZR   = (ZERO_REG0 != 0);

    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic [WIDTH-1:0] rd_data_a_q, rd_data_a_d;
    logic [WIDTH-1:0] rd_data_b_q, rd_data_b_d;
    logic             wr_error_q, wr_error_d;
    logic             multi_hot;
    logic             one_hot;
    logic             wr_valid;

    // Classify the enable bus; a dropped write (multi-hot or masked reg 0) never updates or forwards.
    always_comb begin
        multi_hot = (wr_en_1hot & 16'(wr_en_1hot - 16'd1)) != 16'd0;
        one_hot   = (wr_en_1hot != 16'd0) && !multi_hot;
        wr_valid  = one_hot && !(ZR && wr_en_1hot[0]);
    end

    always_comb begin
        for (int i = 0; i < int'(NREG); i++) begin
            regs_d[i] = regs_q[i];
            if (wr_valid && wr_en_1hot[i]) begin
                regs_d[i] = wr_data;
            end
        end

        rd_data_a_d = regs_q[rd_addr_a];
        rd_data_b_d = regs_q[rd_addr_b];
`ifdef REGBANK_BYPASS_EN
        if (wr_valid && wr_en_1hot[rd_addr_a]) begin
            rd_data_a_d = wr_data;
        end
        if (wr_valid && wr_en_1hot[rd_addr_b]) begin
            rd_data_b_d = wr_data;
        end
`else
        // Read-first: collisions return the pre-write contents already selected above.
`endif
        if (ZR && rd_addr_a == 4'd0) begin
            rd_data_a_d = '0;
        end
        if (ZR && rd_addr_b == 4'd0) begin
            rd_data_b_d = '0;
        end

        // Set has priority over clear.
        wr_error_d = wr_error_q;
        if (clr_error) begin
            wr_error_d = 1'b0;
        end
        if (multi_hot) begin
            wr_error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
            wr_error_q  <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= regs_d[i];
            end
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
            wr_error_q  <= wr_error_d;
        end
    end

    assign rd_data_a = rd_data_a_q;
    assign rd_data_b = rd_data_b_q;
    assign wr_error  = wr_error_q;

endmodule

// File: tb/tb_reg_bank16.sv
// Directed self-checking bench for reg_bank16 (default parameters).
module tb_reg_bank16;

    localparam int unsigned WIDTH = 16;
    localparam bit          ZR    = 1'b0;

    logic             clk;
    logic             rst_n;
    logic [15:0]      wr_en_1hot;
    logic [WIDTH-1:0] wr_data;
    logic [3:0]       rd_addr_a;
    logic [3:0]       rd_addr_b;
    logic [WIDTH-1:0] rd_data_a;
    logic [WIDTH-1:0] rd_data_b;
    logic             clr_error;
    logic             wr_error;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] mdl [16];
    logic [WIDTH-1:0] exp_col;

    reg_bank16 #(.WIDTH(WIDTH), .ZERO_REG0(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_1hot (wr_en_1hot),
        .wr_data    (wr_data),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .clr_error  (clr_error),
        .wr_error   (wr_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] exp_rd(input int idx);
        return (ZR && idx == 0) ? '0 : mdl[idx];
    endfunction

    task automatic write_reg(input int idx, input logic [WIDTH-1:0] data);
        wr_en_1hot = 16'(1) << idx;
        wr_data    = data;
        step();
        if (!(ZR && idx == 0)) mdl[idx] = data;
        wr_en_1hot = 16'h0000;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        rst_n      = 1'b0;
        wr_en_1hot = 16'($urandom);
        wr_data    = 16'($urandom);
        rd_addr_a  = 4'($urandom);
        rd_addr_b  = 4'($urandom);
        clr_error  = 1'b0;

        // 1. Reset with random inputs, then read every address
        for (int c = 0; c < 4; c++) begin
            step();
            wr_en_1hot = 16'($urandom);
            wr_data    = 16'($urandom);
            rd_addr_a  = 4'($urandom);
            rd_addr_b  = 4'($urandom);
        end
        check("rst_rd_a", rd_data_a, 16'h0000);
        check("rst_rd_b", rd_data_b, 16'h0000);
        check("rst_err", 16'(wr_error), 16'h0000);
        wr_en_1hot = 16'h0000;
        rst_n      = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = 4'(i);
            rd_addr_b = 4'(15 - i);
            step();
            check("init_rd_a", rd_data_a, 16'h0000);
            check("init_rd_b", rd_data_b, 16'h0000);
        end

        // 2. Write A500+i then read back crosswise
        for (int i = 0; i < 16; i++) write_reg(i, 16'hA500 + 16'(i));
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = 4'(i);
            rd_addr_b = 4'(15 - i);
            step();
            check("wr_rd_a", rd_data_a, exp_rd(i));
            check("wr_rd_b", rd_data_b, exp_rd(15 - i));
        end
        check("wr_rd_a5_const", rd_data_a, 16'hA50F);

        // 3. Multi-hot write is dropped and flags a sticky error
        write_reg(3, 16'h1111);
        wr_en_1hot = 16'h0018;
        wr_data    = 16'hFFFF;
        step();
        check("mh_err_set", 16'(wr_error), 16'h0001);
        wr_en_1hot = 16'h0000;
        rd_addr_a  = 4'd3;
        rd_addr_b  = 4'd4;
        step();
        check("mh_reg3", rd_data_a, 16'h1111);
        check("mh_reg4", rd_data_b, 16'hA504);
        check("mh_err_hold1", 16'(wr_error), 16'h0001);
        step();
        check("mh_err_hold2", 16'(wr_error), 16'h0001);
        clr_error = 1'b1;
        step();
        clr_error = 1'b0;
        check("mh_err_clr", 16'(wr_error), 16'h0000);

        // 4. Set beats clear at the same edge
        wr_en_1hot = 16'h8001;
        wr_data    = 16'h5A5A;
        clr_error  = 1'b1;
        step();
        wr_en_1hot = 16'h0000;
        clr_error  = 1'b0;
        check("set_vs_clr", 16'(wr_error), 16'h0001);
        rd_addr_a = 4'd0;
        rd_addr_b = 4'd15;
        step();
        check("set_vs_clr_r0", rd_data_a, exp_rd(0));
        check("set_vs_clr_r15", rd_data_b, 16'hA50F);
        clr_error = 1'b1;
        step();
        clr_error = 1'b0;
        check("err_clr2", 16'(wr_error), 16'h0000);

        // 5. Read/write collision on reg 7
        write_reg(7, 16'h0001);
        rd_addr_a = 4'd7;
        rd_addr_b = 4'd6;
`ifdef REGBANK_BYPASS_EN
        exp_col = 16'hBEEF;
`else
        exp_col = 16'h0001;
`endif
        write_reg(7, 16'hBEEF);
        check("col_rd_a", rd_data_a, exp_col);
        check("col_rd_b", rd_data_b, 16'hA506);
        step();
        check("col_next", rd_data_a, 16'hBEEF);
        // A dropped multi-hot write must never be forwarded
        wr_en_1hot = 16'h0081;
        wr_data    = 16'h1234;
        step();
        wr_en_1hot = 16'h0000;
        check("col_mh_nofwd", rd_data_a, 16'hBEEF);
        check("col_mh_err", 16'(wr_error), 16'h0001);

        // 6. Asynchronous reset in the middle of a write burst
        rd_addr_a = 4'd7;
        rd_addr_b = 4'd3;
        write_reg(1, 16'h0BB1);
        write_reg(2, 16'h0BB2);
        wr_en_1hot = 16'h0008;
        wr_data    = 16'h0BB3;
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_rd_a", rd_data_a, 16'h0000);
        check("arst_rd_b", rd_data_b, 16'h0000);
        check("arst_err", 16'(wr_error), 16'h0000);
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        // First edge after release performs a normal write
        wr_en_1hot = 16'h0004;
        wr_data    = 16'h5555;
        rd_addr_a  = 4'd2;
        rd_addr_b  = 4'd3;
`ifdef REGBANK_BYPASS_EN
        exp_col = 16'h5555;
`else
        exp_col = 16'h0000;
`endif
        step();
        mdl[2] = 16'h5555;
        wr_en_1hot = 16'h0000;
        check("rel_rd_a", rd_data_a, exp_col);
        check("rel_rd_b", rd_data_b, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = 4'(i);
            rd_addr_b = 4'(15 - i);
            step();
            check("post_rd_a", rd_data_a, exp_rd(i));
            check("post_rd_b", rd_data_b, exp_rd(15 - i));
        end
        check("post_err", 16'(wr_error), 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
